// File: rtl/seq_div.sv
// rtl/seq_div.sv - restoring sequential divider (DIV/DIVU), one quotient bit per clock
// Optional DIV_ZERO_TRAP_EN: zero divisor finishes immediately with div_zero raised.
module seq_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   state_t           state, state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, quo, dvs;
   logic             sign_a, sign_b, sgn;
   logic             neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   shifted, diff;
   logic             fits;
   logic             trap;

   // WIDTH+1-bit subtract keeps |-2^(WIDTH-1)| and full-range unsigned operands exact
   always_comb begin
      neg_a   = is_signed & dividend[WIDTH-1];
      neg_b   = is_signed & divisor[WIDTH-1];
      mag_a   = neg_a ? -dividend : dividend;
      mag_b   = neg_b ? -divisor : divisor;
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
      fits    = ~diff[WIDTH];
   end

`ifdef DIV_ZERO_TRAP_EN
   assign trap = (divisor == '0);
`else
   assign trap = 1'b0;
   assign div_zero = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = trap ? DONE : CALC;
         CALC: if (cnt == LAST) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         quotient  <= '0;
         remainder <= '0;
         done      <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
         div_zero  <= 1'b0;
`endif
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         cnt       <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         sgn       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sign_a <= neg_a;
                  sign_b <= neg_b;
                  sgn    <= is_signed;
                  quo    <= mag_a;
                  dvs    <= mag_b;
                  rem    <= '0;
                  cnt    <= '0;
`ifdef DIV_ZERO_TRAP_EN
                  if (trap) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     div_zero  <= 1'b1;
                     done      <= 1'b1;
                  end
`endif
               end
            end
            CALC: begin
               // The cycle with cnt == LAST only hands over to FIX
               if (cnt != LAST) begin
                  rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], fits};
                  cnt <= cnt + 1'b1;
               end
            end
            FIX: begin
               quotient  <= (sgn & (sign_a ^ sign_b)) ? -quo : quo;
               remainder <= (sgn & sign_a) ? -rem : rem;
               done      <= 1'b1;
            end
            DONE: begin
               done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
               div_zero <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed self-checking bench for seq_div (WIDTH=32)
module tb_seq_div;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_zero;

   int tests = 0;
   int fails = 0;
   int cyc;
   int pulses;

`ifdef DIV_ZERO_TRAP_EN
   localparam int  ZLAT = 0;
   localparam logic ZFLAG = 1'b1;
   localparam logic [31:0] SZQ = 32'hFFFF_FFFF;
`else
   localparam int  ZLAT = 34;
   localparam logic ZFLAG = 1'b0;
   localparam logic [31:0] SZQ = 32'h0000_0001;
`endif

   seq_div #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .quotient(quotient),
      .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for done; cyc = edges after the accepting edge
   task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      is_signed = sg; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", {31'b0, busy}, 32'd1);
      cyc = 0;
      while (!done && cyc < 100) begin
         @(posedge clk); cyc++; @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input int lat, input logic ez);
      launch(sg, a, b);
      check({tag, "_latency"}, cyc, lat);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_div_zero"}, {31'b0, div_zero}, {31'b0, ez});
      check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd1);
      @(posedge clk); @(negedge clk);
      check({tag, "_done_cleared"}, {31'b0, done}, 32'd0);
      check({tag, "_busy_cleared"}, {31'b0, busy}, 32'd0);
      check({tag, "_quotient_held"}, quotient, eq);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      #12;
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_div_zero", {31'b0, div_zero}, 32'd0);
      @(negedge clk); reset = 1'b1;

      run_op("divu_100_7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         34, 1'b0);
      run_op("div_m7_2",      1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 1'b0);
      run_op("div_7_m2",      1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         34, 1'b0);
      run_op("div_m7_m2",     1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 34, 1'b0);
      run_op("divu_big_2",    1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         34, 1'b0);
      run_op("div_overflow",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         34, 1'b0);
      run_op("divu_max_1",    1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         34, 1'b0);
      run_op("divu_123_0",    1'b0, 32'd123,       32'd0,         32'hFFFF_FFFF, 32'd123,       ZLAT, ZFLAG);
      run_op("div_m5_0",      1'b1, 32'hFFFF_FFFB, 32'd0,         SZQ,           32'hFFFF_FFFB, ZLAT, ZFLAG);

      // Start pulses at cycles 5 and 20 must be ignored
      @(negedge clk);
      is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0; cyc = 0;
      while (!done && cyc < 100) begin
         @(posedge clk); cyc++; @(negedge clk);
         if (cyc == 5 || cyc == 20) begin
            start = 1'b1; dividend = 32'd9; divisor = 32'd3;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("ignore_latency", cyc, 34);
      check("ignore_quotient", quotient, 32'd14);
      check("ignore_remainder", remainder, 32'd2);
      pulses = 1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); @(negedge clk);
         if (done) pulses++;
      end
      check("ignore_one_pulse", pulses, 32'd1);
      check("ignore_quotient_held", quotient, 32'd14);

      // Asynchronous reset in the middle of an operation
      @(negedge clk);
      is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_quotient", quotient, 32'd0);
      check("abort_remainder", remainder, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      @(negedge clk); reset = 1'b1;
      run_op("after_rst_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 34, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
